// File: rtl/cpu_axi_bridge_pkg.sv
// Shared state encodings, AXI IDs and fixed AXI3 attributes
// for the CPU-to-AXI bridge.
package cpu_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_B
  } wr_state_t;

  localparam logic [3:0] INST_ID   = 4'd0;
  localparam logic [3:0] DATA_ID   = 4'd1;
  localparam logic [3:0] AXI_LEN   = 4'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  function automatic logic [2:0] axi_size(
    input logic [1:0] size
  );
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_wr.sv
// Write side of the bridge: one outstanding write,
// AW and W driven independently, then the B response.
module cpu_axi_bridge_wr
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic [1:0]          size,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   data,
  input  logic                hold,
  output logic                addr_ok,
  output logic                data_ok,
  output logic                busy,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  wr_state_t state, state_nx;
  logic      aw_done, w_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= W_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    unique case (state)
      W_IDLE: begin
        addr_ok = req;
        if (req) state_nx = W_REQ;
      end
      W_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready))
          state_nx = W_B;
      end
      W_B: begin
        // a same-cycle data read response owns data_ok
        bready  = !hold;
        data_ok = bvalid && !hold;
        if (bvalid && !hold) state_nx = W_IDLE;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == W_REQ && state_nx == W_REQ) begin
      aw_done <= aw_done || awready;
      w_done  <= w_done || wready;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awaddr <= '0;
      awsize <= '0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (state == W_IDLE && req) begin
      awaddr <= addr;
      awsize <= axi_size(size);
      wdata  <= data;
      wstrb  <= strb;
    end
  end

  assign busy = (state != W_IDLE);

endmodule

// File: rtl/cpu_axi_bridge.sv
// SRAM-like inst/data ports to one AXI3 master.
// BRIDGE_RAW_ADDR_CHECK_EN: only same-word writes block data reads.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  rd_state_t r_state, r_nx;
  logic      data_rd, rd_block;
  logic      pick_data, pick_inst, rd_fire;
  logic      rd_data_hit;
  logic      wr_addr_ok, wr_data_ok, wr_busy;
  logic      unused_inst;

  assign unused_inst = ^{inst_wr, inst_wstrb, inst_wdata};
  assign data_rd     = data_req && !data_wr;

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  assign rd_block = wr_busy &&
    (data_addr[ADDR_W-1:2] == awaddr[ADDR_W-1:2]);
`else
  assign rd_block = wr_busy;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_nx;
  end

  always_comb begin
    r_nx      = r_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    pick_data = 1'b0;
    pick_inst = 1'b0;
    rd_fire   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        pick_data = data_rd && !rd_block;
        pick_inst = inst_req && !pick_data;
        if (pick_data || pick_inst) r_nx = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_nx = R_R;
      end
      R_R: begin
        rready  = 1'b1;
        rd_fire = rvalid;
        if (rvalid) r_nx = R_IDLE;
      end
      default: r_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arid   <= '0;
      araddr <= '0;
      arsize <= '0;
    end else begin
      unique case (1'b1)
        pick_data: begin
          arid   <= DATA_ID;
          araddr <= data_addr;
          arsize <= axi_size(data_size);
        end
        pick_inst: begin
          arid   <= INST_ID;
          araddr <= inst_addr;
          arsize <= axi_size(inst_size);
        end
        default: ;
      endcase
    end
  end

  assign rd_data_hit  = rd_fire && (rid == DATA_ID);
  assign inst_addr_ok = pick_inst;
  assign data_addr_ok = pick_data || wr_addr_ok;
  assign inst_data_ok = rd_fire && (rid == INST_ID);
  assign data_data_ok = rd_data_hit || wr_data_ok;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  cpu_axi_bridge_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr (
    .clk     (clk),
    .resetn  (resetn),
    .req     (data_req && data_wr),
    .size    (data_size),
    .addr    (data_addr),
    .strb    (data_wstrb),
    .data    (data_wdata),
    .hold    (rd_data_hit),
    .addr_ok (wr_addr_ok),
    .data_ok (wr_data_ok),
    .busy    (wr_busy),
    .awaddr  (awaddr),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awid    = DATA_ID;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge.
// Honours BRIDGE_RAW_ADDR_CHECK_EN for the RAW address case.
module tb_cpu_axi_bridge;

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  localparam bit RAW_ADDR = 1'b1;
`else
  localparam bit RAW_ADDR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, rid;
  logic [31:0] araddr, rdata;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  awid, awlen, awcache, wid;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk (clk), .resetn (resetn),
    .inst_req (inst_req), .inst_wr (inst_wr),
    .inst_size (inst_size), .inst_addr (inst_addr),
    .inst_wstrb (inst_wstrb), .inst_wdata (inst_wdata),
    .inst_addr_ok (inst_addr_ok), .inst_data_ok (inst_data_ok),
    .inst_rdata (inst_rdata),
    .data_req (data_req), .data_wr (data_wr),
    .data_size (data_size), .data_addr (data_addr),
    .data_wstrb (data_wstrb), .data_wdata (data_wdata),
    .data_addr_ok (data_addr_ok), .data_data_ok (data_data_ok),
    .data_rdata (data_rdata),
    .arid (arid), .araddr (araddr), .arlen (arlen),
    .arsize (arsize), .arburst (arburst), .arlock (arlock),
    .arcache (arcache), .arprot (arprot),
    .arvalid (arvalid), .arready (arready),
    .rid (rid), .rdata (rdata), .rvalid (rvalid), .rready (rready),
    .awid (awid), .awaddr (awaddr), .awlen (awlen),
    .awsize (awsize), .awburst (awburst), .awlock (awlock),
    .awcache (awcache), .awprot (awprot),
    .awvalid (awvalid), .awready (awready),
    .wid (wid), .wdata (wdata), .wstrb (wstrb), .wlast (wlast),
    .wvalid (wvalid), .wready (wready),
    .bvalid (bvalid), .bready (bready)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0;
    inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = '0; data_wstrb = '0; data_wdata = '0;
    arready = 1'b0; rid = 4'd0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // reset state
    @(negedge clk); #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_arburst", arburst, 1);
    check("rst_awid", awid, 1);
    check("rst_wlast", wlast, 1);
    @(negedge clk); resetn = 1'b1; arready = 1'b1;

    // single inst read
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; #1;
    check("i_aok", inst_addr_ok, 1);
    check("i_daok", data_addr_ok, 0);
    @(negedge clk); inst_req = 1'b0; #1;
    check("i_arvalid", arvalid, 1);
    check("i_araddr", araddr, 32'h1C00_0000);
    check("i_arid", arid, 0);
    check("i_arsize", arsize, 2);
    check("i_aok_low", inst_addr_ok, 0);
    @(negedge clk); #1;
    check("i_rready", rready, 1);
    check("i_dok_early", inst_data_ok, 0);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C; #1;
    check("i_dok", inst_data_ok, 1);
    check("i_rdata", inst_rdata, 32'h0280_0C0C);
    check("i_ddok", data_data_ok, 0);
    @(negedge clk); rvalid = 1'b0; #1;
    check("i_dok_pulse", inst_data_ok, 0);
    check("i_rready_off", rready, 0);

    // arbitration: data read beats inst read
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b0;
    data_addr = 32'h100; data_size = 2'd2; #1;
    check("arb_daok", data_addr_ok, 1);
    check("arb_iaok", inst_addr_ok, 0);
    @(negedge clk); data_req = 1'b0; #1;
    check("arb_arid", arid, 1);
    check("arb_araddr", araddr, 32'h100);
    check("arb_iaok_ar", inst_addr_ok, 0);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1122_3344; #1;
    check("arb_ddok", data_data_ok, 1);
    check("arb_drdata", data_rdata, 32'h1122_3344);
    check("arb_idok", inst_data_ok, 0);
    check("arb_iaok_r", inst_addr_ok, 0);
    @(negedge clk); rvalid = 1'b0; #1;
    check("arb_iaok_late", inst_addr_ok, 1);
    @(negedge clk); inst_req = 1'b0; #1;
    check("arb_arid2", arid, 0);
    check("arb_araddr2", araddr, 32'h1C00_0004);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h1357_9BDF; #1;
    check("arb_idok2", inst_data_ok, 1);

    // write with late awready
    @(negedge clk);
    rvalid = 1'b0; awready = 1'b0; wready = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200;
    data_size = 2'd2; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; #1;
    check("w_daok", data_addr_ok, 1);
    check("w_awv_idle", awvalid, 0);
    @(negedge clk); data_req = 1'b0; #1;
    check("w_awvalid", awvalid, 1);
    check("w_wvalid", wvalid, 1);
    check("w_awaddr", awaddr, 32'h200);
    check("w_wdata", wdata, 32'hDEAD_BEEF);
    check("w_wstrb", wstrb, 4'hF);
    check("w_awsize", awsize, 2);
    @(negedge clk); #1;
    check("w_wvalid_drop", wvalid, 0);
    check("w_awvalid_hold", awvalid, 1);
    @(negedge clk); awready = 1'b1; #1;
    check("w_awvalid_hold2", awvalid, 1);
    check("w_bready_early", bready, 0);
    @(negedge clk); awready = 1'b0; #1;
    check("w_awvalid_drop", awvalid, 0);
    check("w_bready", bready, 1);
    check("w_ddok_early", data_data_ok, 0);
    @(negedge clk); bvalid = 1'b1; #1;
    check("w_ddok", data_data_ok, 1);
    @(negedge clk); bvalid = 1'b0; #1;
    check("w_bready_off", bready, 0);

    // RAW on same address
    awready = 1'b1; wready = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200;
    data_wdata = 32'h0BAD_F00D; #1;
    check("raw_w_daok", data_addr_ok, 1);
    @(negedge clk); data_wr = 1'b0; #1;
    check("raw_blk_req", data_addr_ok, 0);
    @(negedge clk); #1;
    check("raw_blk_b", data_addr_ok, 0);
    @(negedge clk); bvalid = 1'b1; #1;
    check("raw_b_ddok", data_data_ok, 1);
    check("raw_blk_bhs", data_addr_ok, 0);
    @(negedge clk); bvalid = 1'b0; #1;
    check("raw_release", data_addr_ok, 1);
    @(negedge clk); data_req = 1'b0; #1;
    check("raw_araddr", araddr, 32'h200);
    check("raw_arid", arid, 1);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h0BAD_F00D; #1;
    check("raw_rd_ddok", data_data_ok, 1);

    // RAW on a different word
    @(negedge clk);
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200; #1;
    check("rawd_w_daok", data_addr_ok, 1);
    @(negedge clk); data_wr = 1'b0; data_addr = 32'h300; #1;
    check("rawd_daok", data_addr_ok, 32'(RAW_ADDR));
    @(negedge clk); data_req = 1'b0; #1;
    check("rawd_arvalid", arvalid, 32'(RAW_ADDR));
    @(negedge clk);
    rvalid = RAW_ADDR; rid = 4'd1; rdata = 32'h3333_3333; #1;
    check("rawd_rd_ddok", data_data_ok, 32'(RAW_ADDR));
    @(negedge clk);
    rvalid = 1'b0; awready = 1'b1; wready = 1'b1; #1;
    check("rawd_awvalid", awvalid, 1);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #1;
    check("rawd_b_ddok", data_data_ok, 1);

    // inst read and write response together
    @(negedge clk);
    bvalid = 1'b0; awready = 1'b1; wready = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0008;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h204;
    data_wdata = 32'h0000_1234; #1;
    check("cc_iaok", inst_addr_ok, 1);
    check("cc_daok", data_addr_ok, 1);
    @(negedge clk); inst_req = 1'b0; data_req = 1'b0; #1;
    check("cc_arvalid", arvalid, 1);
    check("cc_awvalid", awvalid, 1);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_F00D; bvalid = 1'b1; #1;
    check("cc_idok", inst_data_ok, 1);
    check("cc_ddok", data_data_ok, 1);
    check("cc_irdata", inst_rdata, 32'hCAFE_F00D);

    // data read response holds back write response
    @(negedge clk);
    rvalid = 1'b0; bvalid = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h400; #1;
    check("hd_rd_daok", data_addr_ok, 1);
    @(negedge clk); data_wr = 1'b1; data_addr = 32'h208; #1;
    check("hd_wr_daok", data_addr_ok, 1);
    @(negedge clk); data_req = 1'b0;
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h4444_4444; bvalid = 1'b1; #1;
    check("hd_ddok_rd", data_data_ok, 1);
    check("hd_bready_hold", bready, 0);
    check("hd_drdata", data_rdata, 32'h4444_4444);
    @(negedge clk); rvalid = 1'b0; #1;
    check("hd_bready", bready, 1);
    check("hd_ddok_wr", data_data_ok, 1);

    // reset in the middle of R_AR
    @(negedge clk);
    bvalid = 1'b0; arready = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_000C; #1;
    check("rs_iaok", inst_addr_ok, 1);
    @(negedge clk); inst_req = 1'b0; #1;
    check("rs_arvalid", arvalid, 1);
    #2 resetn = 1'b0; #1;
    check("rs_arvalid_off", arvalid, 0);
    check("rs_araddr_clr", araddr, 0);
    check("rs_rready", rready, 0);
    @(negedge clk);
    resetn = 1'b1; arready = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0010; #1;
    check("rs_iaok2", inst_addr_ok, 1);
    @(negedge clk); inst_req = 1'b0; #1;
    check("rs_arvalid2", arvalid, 1);
    check("rs_araddr2", araddr, 32'h1C00_0010);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h55AA_55AA; #1;
    check("rs_idok", inst_data_ok, 1);
    check("rs_irdata", inst_rdata, 32'h55AA_55AA);
    @(negedge clk); rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
